fft_stage_sequencer: RTL and testbench

//  Sequences an in-place radix-2 DIF FFT over ping-pong sample banks, driving the 8+8-bit complex butterfly
//  (4-cycle pipeline, shared enable, 7-bit twiddle index). Per stage, issues butterfly pair read addresses
//  and the aligned twiddle index. Gates the butterfly enable, delays write addresses to match read plus

---
 rtl/fft_stage_sequencer.sv | 167 ++++++++++++++++
 tb/tb_fft_stage_sequencer.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/fft_stage_sequencer.sv
// Address/twiddle/enable sequencer for an in-place radix-2 DIF FFT over ping-pong banks.
// Define FFT_SCHED_BITREV_EN to add the bit-reversed UNLOAD pass (ul_valid/ul_addr ports).
module fft_stage_sequencer #(
  parameter int N_LOG2 = 10,
  parameter int TW_W   = 7,
  parameter int RD_LAT = 1,
  parameter int BF_LAT = 4
) (
  input  logic              clock_c,
  input  logic              reset,
  input  logic              start,
  input  logic              hold,
  output logic              busy,
  output logic              done,
  output logic [3:0]        stage,
  output logic              rd_en,
  output logic              rd_bank,
  output logic [N_LOG2-1:0] rd_addr_a,
  output logic [N_LOG2-1:0] rd_addr_b,
  output logic [TW_W-1:0]   tw_idx,
  output logic              bf_en,
  output logic              wr_en,
  output logic              wr_bank,
  output logic [N_LOG2-1:0] wr_addr_a,
  output logic [N_LOG2-1:0] wr_addr_b,
`ifdef FFT_SCHED_BITREV_EN
  output logic              ul_valid,
  output logic [N_LOG2-1:0] ul_addr,
`endif
  output logic              result_bank
);
  localparam int DLY = RD_LAT + BF_LAT;
  localparam int DW  = $clog2(DLY + 1);
  localparam int EW  = N_LOG2 - 1;
`ifdef FFT_SCHED_BITREV_EN
  localparam int CW  = N_LOG2;
`else
  localparam int CW  = N_LOG2 - 1;
`endif
  localparam logic [N_LOG2-1:0] ONE = N_LOG2'(1);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_DRAIN, S_UNLOAD, S_FINISH} state_t;
  typedef struct packed {
    logic              vld;
    logic              bank;
    logic [N_LOG2-1:0] a;
    logic [N_LOG2-1:0] b;
  } wr_ent_t;

  state_t                      state, state_n;
  logic [CW-1:0]               cnt;
  logic [DW-1:0]               dcnt;
  logic                        res_q;
  logic [3:0]                  sh;
  logic [N_LOG2-1:0]           kx, jx, ax, bx;
  logic [EW-1:0]               ex;
  logic                        adv, issue, k_last, d_last, s_last;
  wr_ent_t                     ent_in;
  wr_ent_t [DLY-1:0]           wr_pipe;
  logic [RD_LAT-1:0][TW_W-1:0] tw_pipe;

  assign adv    = ~hold;
  assign issue  = (state == S_ISSUE) && adv;
  assign k_last = &cnt[N_LOG2-2:0];
  assign d_last = dcnt == DW'(DLY - 1);
  assign s_last = stage == 4'(N_LOG2 - 1);

  // Pair k: a is k with a zero spliced in at bit sh, b is a with that bit set.
  always_comb begin
    sh = 4'(N_LOG2 - 1) - stage;
    kx = N_LOG2'(cnt[N_LOG2-2:0]);
    jx = kx & ((ONE << sh) - ONE);
    ax = ((kx >> sh) << (sh + 4'd1)) | jx;
    bx = ax | (ONE << sh);
    ex = EW'(jx << stage);
  end

  always_comb begin
    ent_in = '0;
    if (issue) ent_in = '{vld: 1'b1, bank: ~stage[0], a: ax, b: bx};
  end

  // Write-side and twiddle delay lines freeze with the butterfly so alignment survives hold.
  always_ff @(posedge clock_c) begin
    if (reset) begin
      wr_pipe <= '0;
      tw_pipe <= '0;
    end else if (adv) begin
      wr_pipe[0] <= ent_in;
      tw_pipe[0] <= issue ? TW_W'(ex >> (EW - TW_W)) : '0;
      for (int i = 1; i < DLY; i++) wr_pipe[i] <= wr_pipe[i-1];
      for (int i = 1; i < RD_LAT; i++) tw_pipe[i] <= tw_pipe[i-1];
    end
  end

  always_ff @(posedge clock_c) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  always_ff @(posedge clock_c) begin
    if (reset) begin
      stage <= '0;
      cnt   <= '0;
      dcnt  <= '0;
      res_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          stage <= '0;
          cnt   <= '0;
          dcnt  <= '0;
        end
        S_ISSUE:  if (adv) cnt <= k_last ? '0 : cnt + CW'(1);
        S_DRAIN: if (adv) begin
          dcnt <= d_last ? '0 : dcnt + DW'(1);
          if (d_last && !s_last) stage <= stage + 4'd1;
          if (d_last && s_last)  res_q <= ~stage[0];
        end
        S_UNLOAD: if (adv) cnt <= cnt + CW'(1);
        S_FINISH: stage <= '0;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:   if (start) state_n = S_ISSUE;
      S_ISSUE:  if (adv && k_last) state_n = S_DRAIN;
      S_DRAIN:  if (adv && d_last) begin
        if (!s_last) state_n = S_ISSUE;
`ifdef FFT_SCHED_BITREV_EN
        else         state_n = S_UNLOAD;
`else
        else         state_n = S_FINISH;
`endif
      end
      S_UNLOAD: if (adv && &cnt) state_n = S_FINISH;
      S_FINISH: state_n = S_IDLE;
      default:  state_n = S_IDLE;
    endcase
  end

  always_comb begin
    busy        = state inside {S_ISSUE, S_DRAIN, S_UNLOAD};
    done        = state == S_FINISH;
    rd_en       = issue;
    rd_bank     = stage[0];
    rd_addr_a   = (state == S_ISSUE) ? ax : '0;
    rd_addr_b   = (state == S_ISSUE) ? bx : '0;
    tw_idx      = tw_pipe[RD_LAT-1];
    bf_en       = busy & adv;
    wr_en       = wr_pipe[DLY-1].vld & adv;
    wr_bank     = wr_pipe[DLY-1].bank;
    wr_addr_a   = wr_pipe[DLY-1].a;
    wr_addr_b   = wr_pipe[DLY-1].b;
    result_bank = res_q;
`ifdef FFT_SCHED_BITREV_EN
    ul_valid = (state == S_UNLOAD) & adv;
    ul_addr  = '0;
    if (state == S_UNLOAD)
      for (int i = 0; i < N_LOG2; i++) ul_addr[i] = cnt[N_LOG2-1-i];
`endif
  end
endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Scoreboard bench for fft_stage_sequencer: expected read/write/done streams queued at start,
// popped by a negedge monitor whenever the DUT strobes.
module tb_fft_stage_sequencer;
  localparam int N_LOG2 = 10;
  localparam int TW_W   = 7;
  localparam int N      = 1 << N_LOG2;
`ifdef FFT_SCHED_BITREV_EN
  localparam int ULN = N;
`else
  localparam int ULN = 0;
`endif

  logic clock_c = 1'b0;
  logic reset, start, hold;
  logic busy, done, rd_en, rd_bank, bf_en, wr_en, wr_bank, result_bank;
  logic [3:0] stage;
  logic [N_LOG2-1:0] rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b;
  logic [TW_W-1:0] tw_idx;
`ifdef FFT_SCHED_BITREV_EN
  logic ul_valid;
  logic [N_LOG2-1:0] ul_addr;
`endif

  fft_stage_sequencer #(.N_LOG2(N_LOG2), .TW_W(TW_W), .RD_LAT(1), .BF_LAT(4)) dut (
    .clock_c(clock_c), .reset(reset), .start(start), .hold(hold),
    .busy(busy), .done(done), .stage(stage), .rd_en(rd_en), .rd_bank(rd_bank),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .tw_idx(tw_idx), .bf_en(bf_en),
    .wr_en(wr_en), .wr_bank(wr_bank), .wr_addr_a(wr_addr_a), .wr_addr_b(wr_addr_b),
`ifdef FFT_SCHED_BITREV_EN
    .ul_valid(ul_valid), .ul_addr(ul_addr),
`endif
    .result_bank(result_bank)
  );

  always #5 clock_c = ~clock_c;

  int cyc = 0;
  int t0 = 0;
  always @(posedge clock_c) cyc <= cyc + 1;

  typedef struct { int bank; int a; int b; int tw; } rd_t;
  typedef struct { int bank; int a; int b; } wr_t;
  typedef struct { int idx; int a; int b; int tw; } spot_t;
  typedef struct { int done_cyc; int busy_n; int wr_n; int first_busy; int res; } run_t;

  rd_t   rq[$];
  wr_t   wq[$];
  spot_t sq[$];
  run_t  dq[$];
  int    uq[$];
  int    n_vec = 0;
  int    n_miss = 0;
  logic  hold_issue = 1'b0;

  task automatic chk(string nm, int act, int exp);
    n_vec++;
    if (act != exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc - t0);
    end
  endtask

  // Classic DIF loop nest: stage, group, offset within group.
  task automatic push_run(int extra);
    int span, a, r;
    for (int s = 0; s < N_LOG2; s++) begin
      span = N >> (s + 1);
      for (int g = 0; g < N / (2 * span); g++)
        for (int j = 0; j < span; j++) begin
          a = g * 2 * span + j;
          rq.push_back('{s % 2, a, a + span, (j * (1 << s)) >> (N_LOG2 - 1 - TW_W)});
          wq.push_back('{1 - (s % 2), a, a + span});
        end
    end
    sq.push_back('{5, 5, 517, 1});
    sq.push_back('{512 + 300, 556, 812, 22});
    sq.push_back('{9 * 512 + 7, 14, 15, 0});
    for (int m = 0; m < ULN; m++) begin
      r = 0;
      for (int i = 0; i < N_LOG2; i++) r = r | (((m >> i) & 1) << (N_LOG2 - 1 - i));
      uq.push_back(r);
    end
    dq.push_back('{5171 + extra + ULN, 5170 + extra + ULN, 5120, 1, 0});
  endtask

  // Monitor
  int   rel, busy_n = 0, wr_n = 0, rd_cnt = 0, first_busy = 0, tw_exp = 0, spot_tw = 0;
  logic tw_pend = 0, spot_pend = 0, rst_chk = 0;
  rd_t  re;
  wr_t  we;
  run_t rr;
  always @(negedge clock_c) begin
    rel = cyc - t0;
    if (rst_chk) begin
      chk("reset_outputs", int'(busy | done | (|stage) | rd_en | rd_bank | (|rd_addr_a) | (|rd_addr_b)
          | (|tw_idx) | bf_en | wr_en | wr_bank | (|wr_addr_a) | (|wr_addr_b) | result_bank), 0);
      rst_chk = 0;
    end
    if (tw_pend) begin chk("tw_idx", int'(tw_idx), tw_exp); tw_pend = 0; end
    if (spot_pend) begin chk("spot_tw", int'(tw_idx), spot_tw); spot_pend = 0; end
    if (hold) begin
      chk("hold_gate", int'({rd_en, bf_en, wr_en}), 0);
      if (hold_issue && rq.size() > 0) begin
        chk("hold_addr_a", int'(rd_addr_a), rq[0].a);
        chk("hold_addr_b", int'(rd_addr_b), rq[0].b);
      end
    end
    if (rd_en) begin
      if (rq.size() == 0) chk("unexpected_rd", 1, 0);
      else begin
        re = rq.pop_front();
        chk("rd_addr_a", int'(rd_addr_a), re.a);
        chk("rd_addr_b", int'(rd_addr_b), re.b);
        chk("rd_bank", int'(rd_bank), re.bank);
        tw_exp = re.tw;
        tw_pend = 1;
      end
      if (sq.size() > 0 && rd_cnt == sq[0].idx) begin
        chk("spot_a", int'(rd_addr_a), sq[0].a);
        chk("spot_b", int'(rd_addr_b), sq[0].b);
        spot_tw = sq[0].tw;
        spot_pend = 1;
        sq.delete(0);
      end
      rd_cnt++;
    end
    if (wr_en) begin
      if (wq.size() == 0) chk("unexpected_wr", 1, 0);
      else begin
        we = wq.pop_front();
        chk("wr_addr_a", int'(wr_addr_a), we.a);
        chk("wr_addr_b", int'(wr_addr_b), we.b);
        chk("wr_bank", int'(wr_bank), we.bank);
      end
      wr_n++;
    end
`ifdef FFT_SCHED_BITREV_EN
    if (ul_valid) begin
      if (uq.size() == 0) chk("unexpected_ul", 1, 0);
      else chk("ul_addr", int'(ul_addr), uq.pop_front());
    end
`endif
    if (busy) begin
      if (busy_n == 0) first_busy = rel;
      busy_n++;
    end
    if (done) begin
      if (dq.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        rr = dq.pop_front();
        chk("done_cycle", rel, rr.done_cyc);
        chk("busy_cycles", busy_n, rr.busy_n);
        chk("wr_count", wr_n, rr.wr_n);
        chk("first_busy", first_busy, rr.first_busy);
        chk("result_bank", int'(result_bank), rr.res);
        chk("busy_at_done", int'(busy), 0);
      end
      busy_n = 0; wr_n = 0; rd_cnt = 0;
    end
    if (reset) begin
      tw_pend = 0; spot_pend = 0; rst_chk = 1;
      busy_n = 0; wr_n = 0; rd_cnt = 0;
    end
  end

  task automatic wait_cyc(int n);
    while (cyc - t0 < n) begin @(posedge clock_c); #1; end
  endtask

  task automatic wait_done(int lim);
    int i;
    i = 0;
    while (!done && i < lim) begin @(negedge clock_c); i++; end
    if (!done) chk("done_timeout", 0, 1);
    @(posedge clock_c); #1;
  endtask

  task automatic pulse_start();
    t0 = cyc;
    start = 1'b1;
    @(posedge clock_c); #1;
    start = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; hold = 1'b0;
    repeat (3) @(posedge clock_c);
    #1 reset = 1'b0;
    repeat (2) begin @(posedge clock_c); #1; end

    // Plain run
    push_run(0);
    pulse_start();
    wait_done(7000);

    // Three hold cycles in stage 4 issue
    push_run(3);
    pulse_start();
    wait_cyc(2200);
    hold = 1'b1; hold_issue = 1'b1;
    wait_cyc(2203);
    hold = 1'b0; hold_issue = 1'b0;
    wait_done(7000);

    // Reset during stage 6 issue, then a clean run
    push_run(0);
    pulse_start();
    wait_cyc(3200);
    reset = 1'b1;
    @(posedge clock_c); #1;
    reset = 1'b0;
    rq.delete(); wq.delete(); sq.delete(); dq.delete(); uq.delete();
    repeat (20) begin @(posedge clock_c); #1; end
    push_run(0);
    pulse_start();
    wait_done(7000);

    // Start with hold in IDLE, hold two issue cycles, re-pulse start while busy
    push_run(2);
    t0 = cyc;
    start = 1'b1; hold = 1'b1;
    @(posedge clock_c); #1;
    start = 1'b0; hold_issue = 1'b1;
    @(posedge clock_c); #1;
    @(posedge clock_c); #1;
    hold = 1'b0; hold_issue = 1'b0;
    wait_cyc(100);
    start = 1'b1;
    @(posedge clock_c); #1;
    start = 1'b0;
    wait_done(7000);

    repeat (10) begin @(posedge clock_c); #1; end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
